// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered EX-stage ALU with NZCV flags and a valid/ready
// handshake. Operands are latched on acceptance and evaluated one cycle later.
// Optional feature macro: ALU_MUL_EN compiles in an iterative shift-add
// multiplier for opcode 1000. Without it, opcode 1000 is reported as illegal.
module alu_exec_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             illegal
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam int         CW      = $clog2(WIDTH);
`endif

  // EXEC is the evaluation cycle between acceptance and DONE; it also
  // registers the finished product coming out of MUL.
`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [3:0]       op_r;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
`endif

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] res_s;
  logic             c_s;
  logic             v_s;
  logic             ill_s;

  // Handshake outputs are decoded from state only.
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);

  // Evaluate the latched operation; the multiplier product arrives via acc_r.
  always_comb begin
    sum_s  = {1'b0, a_r} + {1'b0, b_r};
    diff_s = {1'b0, a_r} - {1'b0, b_r};
    res_s  = '0;
    c_s    = 1'b0;
    v_s    = 1'b0;
    ill_s  = 1'b0;
    case (op_r)
      OP_AND:  res_s = a_r & b_r;
      OP_OR:   res_s = a_r | b_r;
      OP_ADD: begin
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB: begin
        res_s = diff_s[WIDTH-1:0];
        c_s   = ~diff_s[WIDTH];
        v_s   = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_PASS: res_s = b_r;
      OP_NOR:  res_s = ~(a_r | b_r);
`ifdef ALU_MUL_EN
      OP_MUL:  res_s = acc_r;
`endif
      default: ill_s = 1'b1;
    endcase
  end

  // Control FSM, operand latches, multiplier iteration and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= 4'b0000;
      result  <= '0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      illegal <= 1'b0;
`ifdef ALU_MUL_EN
      acc_r   <= '0;
      cnt_r   <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r  <= op_a;
            b_r  <= op_b;
            op_r <= alu_op;
`ifdef ALU_MUL_EN
            if (alu_op == OP_MUL) begin
              acc_r   <= '0;
              cnt_r   <= '0;
              state_r <= MUL;
            end else begin
              state_r <= EXEC;
            end
`else
            state_r <= EXEC;
`endif
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          // One multiplier bit per cycle, LSB first: shift A up, B down.
          acc_r <= acc_r + (b_r[0] ? a_r : '0);
          a_r   <= a_r << 1;
          b_r   <= b_r >> 1;
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_r <= EXEC;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
`endif
        EXEC: begin
          result  <= res_s;
          flag_n  <= res_s[WIDTH-1];
          flag_z  <= (res_s == '0);
          flag_c  <= c_s;
          flag_v  <= v_s;
          illegal <= ill_s;
          state_r <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed scoreboard bench for alu_exec_unit (WIDTH = 64).
// Honours ALU_MUL_EN to choose the expected behaviour of opcode 1000.
module tb_alu_exec_unit;

  localparam int W = 64;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_op;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_n, flag_z, flag_c, flag_v, illegal;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] r;
    logic         n, z, c, v, ill;
    logic [7:0]   lat;
  } exp_t;

  exp_t sbq[$];

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag_n(flag_n), .flag_z(flag_z),
    .flag_c(flag_c), .flag_v(flag_v), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic n, input logic z,
                              input logic c, input logic v, input logic ill,
                              input logic [7:0] lat);
    exp_t e;
    e.r = r; e.n = n; e.z = z; e.c = c; e.v = v; e.ill = ill; e.lat = lat;
    return e;
  endfunction

  // Reference model: overflow derived from a sign-extended W+1 bit result.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] sx;
    e = mk('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    case (op)
      OP_AND:  e.r = a & b;
      OP_OR:   e.r = a | b;
      OP_NOR:  e.r = ~(a | b);
      OP_PASS: e.r = b;
      OP_ADD: begin
        e.r = a + b;
        e.c = ({1'b0, a} + {1'b0, b}) > {1'b0, {W{1'b1}}};
        sx  = {a[W-1], a} + {b[W-1], b};
        e.v = sx[W] ^ sx[W-1];
      end
      OP_SUB: begin
        e.r = a - b;
        e.c = (a >= b);
        sx  = {a[W-1], a} - {b[W-1], b};
        e.v = sx[W] ^ sx[W-1];
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        e.r   = a * b;
        e.lat = 8'(W + 1);
      end
`endif
      default: e.ill = 1'b1;
    endcase
    e.z = (e.r == '0);
    e.n = e.r[W-1];
    return e;
  endfunction

  // Wait for in_ready, present the request for one edge, then scramble inputs.
  task automatic accept(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", W'(in_ready), W'(1));
    in_valid = 1'b1; alu_op = op; op_a = a; op_b = b;
    if (push) sbq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_op   = 4'($urandom);
    op_a     = {$urandom, $urandom};
    op_b     = {$urandom, $urandom};
    check("in_ready_after_accept", W'(in_ready), W'(0));
  endtask

  // Wait (bounded) for out_valid, then pop and compare the expected entry.
  task automatic collect(input string tag);
    int   lat = 0;
    exp_t e;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_sb_nonempty"}, W'(sbq.size() != 0), W'(1));
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check({tag, "_latency"}, W'(lat), W'(e.lat));
      check({tag, "_result"}, result, e.r);
      check({tag, "_nzcv"}, W'({flag_n, flag_z, flag_c, flag_v}), W'({e.n, e.z, e.c, e.v}));
      check({tag, "_illegal"}, W'(illegal), W'(e.ill));
    end
  endtask

  task automatic consume(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_consumed"}, W'({out_valid, in_ready}), W'(2'b01));
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input exp_t e);
    accept(op, a, b, e, 1'b1);
    collect(tag);
    consume(tag);
  endtask

  logic [3:0] pool [8];
  logic [3:0] rop;
  logic [W-1:0] ra, rb;
  int vcount;

  initial begin
    pool = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASS, OP_NOR, OP_MUL, 4'b0101};
    rst = 1'b1; in_valid = 1'b0; alu_op = 4'b0000; op_a = '0; op_b = '0; out_ready = 1'b1;
    #1;
    check("reset_handshake", W'({in_ready, out_valid}), W'(2'b10));
    check("reset_result", result, '0);
    check("reset_flags", W'({flag_n, flag_z, flag_c, flag_v, illegal}), W'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run("add_ovf", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
        mk(64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1));
    run("add_carry", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
        mk(64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1));
    run("sub_eq", OP_SUB, 64'h1234, 64'h1234,
        mk(64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1));
    run("sub_borrow", OP_SUB, 64'd0, 64'd1,
        mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
    run("and", OP_AND, 64'hF0F0, 64'h0FF0, mk(64'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
    run("or", OP_OR, 64'hF0F0, 64'h0FF0, mk(64'hFFF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
    run("nor", OP_NOR, 64'hF0F0, 64'h0FF0,
        mk(64'hFFFF_FFFF_FFFF_000F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
    run("passb", OP_PASS, 64'hF0F0, 64'h0FF0, mk(64'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
`ifdef ALU_MUL_EN
    run("mul", OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
        mk(64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd65));
`else
    run("mul_off", OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
        mk(64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1));
`endif
    run("illegal_op", 4'b1111, 64'hDEAD, 64'hBEEF, mk(64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1));

    for (int i = 0; i < 6; i++) begin
      rop = pool[$urandom_range(0, 7)];
      ra  = {$urandom, $urandom};
      rb  = (i == 0) ? ra : {$urandom, $urandom};
      run("random", rop, ra, rb, model(rop, ra, rb));
    end

    // Backpressure: result held, in_ready low, stray request ignored.
    out_ready = 1'b0;
    accept(OP_AND, 64'hF0F0, 64'h0FF0, mk(64'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1), 1'b1);
    collect("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      alu_op = OP_ADD; op_a = 64'd5; op_b = 64'd7;
      @(posedge clk);
      #1;
      check("bp_hold_valid", W'({out_valid, in_ready}), W'(2'b10));
      check("bp_hold_result", result, 64'h00F0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    consume("bp");
    vcount = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid) vcount++;
    end
    check("bp_stray_ignored", W'(vcount), W'(0));

    // Asynchronous reset while a request is in flight.
`ifdef ALU_MUL_EN
    accept(OP_MUL, 64'd3, 64'd5, mk('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0), 1'b0);
`else
    out_ready = 1'b0;
    accept(OP_ADD, 64'd3, 64'd5, mk('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0), 1'b0);
`endif
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_handshake", W'({in_ready, out_valid}), W'(2'b10));
    check("rst_mid_result", result, '0);
    check("rst_mid_flags", W'({flag_n, flag_z, flag_c, flag_v, illegal}), W'(0));
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    vcount = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) vcount++;
    end
    check("rst_no_late_valid", W'(vcount), W'(0));
    check("rst_idle_ready", W'(in_ready), W'(1));

    run("post_rst_sub", OP_SUB, 64'd10, 64'd3, mk(64'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
